// File: rtl/div_nr_param.sv
// Purpose : iterative non-restoring divider, signed or unsigned, one quotient bit per clock.
// Latency : WIDTH+1 clocks from accept to done (1 clock for a zero divisor).
// Backpr. : start is only taken while busy=0; requests during an operation are dropped.
//
// Ports:
//   clock, reset_n            - clock and asynchronous active-low reset
//   start, sign_mode          - launch request and mode (1 = two's complement)
//   dividend, divisor         - operands, captured together with start
//   q, r                      - registered quotient / remainder of the last operation
//   busy, done, dbz           - in-flight flag, one-cycle completion pulse, divide-by-zero flag
module div_nr_param #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] acc;      // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH:0]  p;         // signed partial remainder, one bit wider than the operands
    logic [WIDTH:0]  b;         // divisor magnitude, zero-extended
    logic            q_neg;
    logic            r_neg;
    logic            dz;        // current operation has a zero divisor

    // Operand magnitudes. Negating -2^(WIDTH-1) yields the same bit pattern,
    // which read as unsigned is exactly the required magnitude.
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    assign dvd_neg = sign_mode & dividend[WIDTH-1];
    assign dvs_neg = sign_mode & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;

    // One non-restoring step: shift the next dividend bit into the partial
    // remainder, then add or subtract the divisor depending on its sign.
    logic [WIDTH:0] p_sh;
    logic [WIDTH:0] p_nxt;

    assign p_sh  = {p[WIDTH-1:0], acc[WIDTH-1]};
    assign p_nxt = p[WIDTH] ? (p_sh + b) : (p_sh - b);

    // Final correction: a negative partial remainder is restored by one add.
    // The restored value is below the divisor, so it fits in WIDTH bits.
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

    assign r_mag = p[WIDTH] ? (p[WIDTH-1:0] + b[WIDTH-1:0]) : p[WIDTH-1:0];
    assign q_res = q_neg ? -acc : acc;
    assign r_res = r_neg ? -r_mag : r_mag;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            p     <= '0;
            b     <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            dz    <= 1'b0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        cnt   <= '0;
                        p     <= '0;
                        q_neg <= dvd_neg ^ dvs_neg;
                        r_neg <= dvd_neg;
                        if (divisor == '0) begin
                            // Keep the raw dividend: it is returned unchanged as r.
                            dz    <= 1'b1;
                            acc   <= dividend;
                            b     <= '0;
                            state <= FIX;
                        end else begin
                            dz    <= 1'b0;
                            acc   <= dvd_mag;
                            b     <= {1'b0, dvs_mag};
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    p   <= p_nxt;
                    acc <= {acc[WIDTH-2:0], ~p_nxt[WIDTH]};
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                FIX: begin
                    if (dz) begin
                        q   <= '1;
                        r   <= acc;
                        dbz <= 1'b1;
                    end else begin
                        q   <= q_res;
                        r   <= r_res;
                        dbz <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_nr_param.sv
// Purpose : self-checking bench for div_nr_param at WIDTH=32.
// Latency : reference model tracks accept-to-done timing and results cycle by cycle.
// Backpr. : stimulus issues start only at done/idle points, plus ignored starts while busy.
module tb_div_nr_param;

    localparam int W = 32;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic         sign_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         dbz;

    int total = 0;
    int bad   = 0;

    div_nr_param #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .sign_mode (sign_mode),
        .dividend  (dividend),
        .divisor   (divisor),
        .q         (q),
        .r         (r),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } res_t;

    // Plain integer division in 64-bit arithmetic; SV '/' and '%' truncate toward zero.
    function automatic res_t model_div(input logic sm, input logic [W-1:0] a, input logic [W-1:0] d);
        res_t   res;
        longint sa;
        longint sd;
        longint lq;
        longint lr;
        if (d == '0) begin
            res.q   = '1;
            res.r   = a;
            res.dbz = 1'b1;
        end else begin
            sa = sm ? longint'({{32{a[W-1]}}, a}) : longint'({32'b0, a});
            sd = sm ? longint'({{32{d[W-1]}}, d}) : longint'({32'b0, d});
            lq = sa / sd;
            lr = sa % sd;
            res.q   = lq[W-1:0];
            res.r   = lr[W-1:0];
            res.dbz = 1'b0;
        end
        return res;
    endfunction

    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_q    = '0;
    logic [W-1:0] m_r    = '0;
    logic         m_dbz  = 1'b0;
    int           m_left = 0;
    res_t         pend   = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_dbz  <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_q    <= pend.q;
                    m_r    <= pend.r;
                    m_dbz  <= pend.dbz;
                end
                m_left <= m_left - 1;
            end else if (start) begin
                pend   <= model_div(sign_mode, dividend, divisor);
                m_left <= (divisor == '0) ? 1 : W + 1;
                m_busy <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        chk("cyc_busy", busy, m_busy);
        chk("cyc_done", done, m_done);
        chk("cyc_q",    q,    m_q);
        chk("cyc_r",    r,    m_r);
        chk("cyc_dbz",  dbz,  m_dbz);
    end

    // ---------------- directed operations ----------------
    // Drives start away from the clock edge, waits (bounded) for done and
    // returns on the negedge where done is high, so the caller can chain.
    task automatic run_op(input string nm, input logic sm, input logic [W-1:0] a,
                          input logic [W-1:0] d, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic edbz,
                          input int elat, input int inj_at);
        int n;
        int bc;
        bit to;
        start     = 1'b1;
        sign_mode = sm;
        dividend  = a;
        divisor   = d;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        n  = 0;
        bc = 0;
        to = 1'b0;
        while (!to) begin
            @(negedge clock);
            if (done) break;
            if (busy) bc++;
            if (n == inj_at) begin
                start     = 1'b1;
                sign_mode = ~sm;
                dividend  = 32'd55;
                divisor   = 32'd5;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            n++;
            if (n > 200) to = 1'b1;
        end
        if (to) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=no_done required=done_within_%0d", nm, elat);
        end
        chk({nm, "_lat"},  n,    elat);
        chk({nm, "_busy"}, bc,   elat);
        chk({nm, "_q"},    q,    eq);
        chk({nm, "_r"},    r,    er);
        chk({nm, "_dbz"},  dbz,  edbz);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    res_t pm;

    initial begin
        start     = 1'b0;
        sign_mode = 1'b0;
        dividend  = '0;
        divisor   = '0;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;

        // Reset state.
        @(negedge clock);
        @(negedge clock);
        chk("rst_q",    q,    0);
        chk("rst_r",    r,    0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz",  dbz,  0);

        // Pin the model against hand-computed values.
        pm = model_div(1'b0, 32'd7, 32'd2);
        chk("model_u7_2", {pm.q, pm.r}, {32'h3, 32'h1});
        pm = model_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("model_sm7_2", {pm.q, pm.r}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        pm = model_div(1'b1, 32'd7, 32'hFFFF_FFFE);
        chk("model_s7_m2", {pm.q, pm.r}, {32'hFFFF_FFFD, 32'h1});
        pm = model_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("model_ovf", {pm.q, pm.r}, {32'h8000_0000, 32'h0});
        pm = model_div(1'b0, 32'd5, 32'd0);
        chk("model_dz", {pm.q, pm.r, 31'b0, pm.dbz}, {32'hFFFF_FFFF, 32'h5, 32'h1});

        // Release just after a negedge; the following posedge takes start.
        reset_n = 1'b1;

        run_op("u7_2",     1'b0, 32'd7,          32'd2,          32'h3,          32'h1,          1'b0, 33, -1);
        run_op("s_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33, -1);
        run_op("s7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h1,          1'b0, 33, -1);
        run_op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          1'b0, 33, -1);
        run_op("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'h0,          1'b0, 33, -1);
        run_op("u_dz",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'h5,          1'b1, 1,  -1);
        run_op("s_dz",     1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'h5,          1'b1, 1,  -1);
        run_op("u6_3",     1'b0, 32'd6,          32'd3,          32'h2,          32'h0,          1'b0, 33, -1);
        run_op("u_big",    1'b0, 32'h8000_0000,  32'h8000_0001,  32'h0,          32'h8000_0000,  1'b0, 33, -1);
        run_op("s_min_2",  1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'h0,          1'b0, 33, -1);
        run_op("s_m1_min", 1'b1, 32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          32'hFFFF_FFFF,  1'b0, 33, -1);
        run_op("u_ff_ff",  1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h1,          32'h0,          1'b0, 33, -1);

        // Start during CALC is ignored; the next op launches in the done cycle.
        run_op("s_m100_7", 1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33, 10);
        run_op("u1000_10", 1'b0, 32'd1000,       32'd10,         32'd100,        32'h0,          1'b0, 33, -1);

        // Reset in the middle of CALC.
        start     = 1'b1;
        sign_mode = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (14) @(posedge clock);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_q",    q,    0);
        chk("mid_rst_r",    r,    0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_dbz",  dbz,  0);
        repeat (3) @(negedge clock);
        chk("mid_rst_nodone", done, 0);
        #1 reset_n = 1'b1;
        run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, -1);

        repeat (3) @(negedge clock);
        chk("end_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_nr_param.md
DIV_NR_PARAM -- requirements
Module: div_nr_param

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port start  input  1  request a division; sampled only when busy=0.
REQ-005 Port sign_mode  input  1  1 = signed (two's complement), 0 = unsigned; sampled with start.
REQ-006 Port dividend  input  WIDTH  numerator; sampled with start.
REQ-007 Port divisor  input  WIDTH  denominator; sampled with start.
REQ-008 Port q  output  WIDTH  registered quotient.
REQ-009 Port r  output  WIDTH  registered remainder.
REQ-010 Port busy  output  1  high while an operation is in flight.
REQ-011 Port done  output  1  one-cycle pulse; q/r/dbz valid on and after it.
REQ-012 Port dbz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-013 States: IDLE, CALC, FIX; reset state IDLE.
REQ-014 Accept: start=1 in IDLE at edge E0 latches operands and mode, sets busy=1 after E0.
REQ-015 Accept: start while busy=1 is ignored; in-flight operands are unaffected.
REQ-016 Signed mode: operand magnitudes are formed; the quotient sign is dividend[MSB] XOR divisor[MSB]; the remainder sign is dividend[MSB].
REQ-017 Unsigned mode: operands are used unmodified; result signs are positive.
REQ-018 Magnitude register and partial remainder are WIDTH+1 bits wide, so a magnitude of 2^(WIDTH-1) does not overflow.
REQ-019 CALC: one non-restoring step per cycle, exactly WIDTH cycles (edges E1..E_WIDTH).
REQ-020 CALC step: add the divisor if the partial remainder is negative, otherwise subtract it; shift in the inverted sign bit as the quotient bit.
REQ-021 A WIDTH-sized iteration counter ends CALC; the counter wraps to 0 on exit.
REQ-022 FIX at edge E_(WIDTH+1):
  - restore the remainder (add the divisor if negative);
  - apply the signs;
  - register q and r;
  - done=1 for that cycle; busy=0; return to IDLE.
REQ-023 Normal latency: done is high in the cycle after edge E_(WIDTH+1), i.e. WIDTH+1 clocks after accept.
REQ-024 Results: quotient truncates toward zero; |r| < |divisor|; dividend = q*divisor + r (mod 2^WIDTH).
REQ-025 Divisor zero path: skip CALC and go IDLE->FIX.
  - Outputs: q = all ones, r = dividend unmodified, dbz=1.
  - done follows edge E1 (latency 1).
REQ-026 Signed overflow (dividend = -2^(WIDTH-1), divisor = -1): q = -2^(WIDTH-1), r = 0, dbz=0; no special flag.
REQ-027 q, r and dbz hold their values until the next FIX; they do not change during CALC.
REQ-028 dbz is cleared at the FIX of any operation with a nonzero divisor.
REQ-029 start=1 in the same cycle done=1 is accepted, because busy=0 then; back-to-back operations have no idle gap.

Reset
REQ-030 reset_n=0 asynchronously forces the following to 0: state IDLE, q, r, busy, done, dbz, and the counter.
REQ-031 Reset mid-CALC aborts the operation; done is not produced, and the first start after release is handled normally.
REQ-032 Release of reset_n is synchronous to clock; start sampled on the first edge after release is honoured.

Verification (WIDTH=32)
REQ-033 Unsigned 7/2, sign_mode=0 -> q=0x00000003, r=0x00000001; done 33 clocks after accept; busy high for 33 cycles.
REQ-034 Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=0x00000001.
REQ-035 Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, dbz=0; unsigned 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0.
REQ-036 Divide by zero: 5/0 in either mode -> q=0xFFFFFFFF, r=0x00000005, dbz=1, done one clock after accept; the next 6/3 clears dbz and gives q=2, r=0.
REQ-037 Start pulsed at cycle 10 of CALC with new operands -> ignored; the original result is returned; a start in the done cycle launches the next operation immediately.
REQ-038 reset_n low at CALC cycle 15 -> all outputs 0 immediately with no done; after release, 100/7 -> q=14, r=2.
